// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the MIPS subset: request kind codes, opcodes, funct codes,
// and the loader state encoding. The decoder bench uses the same tables.
package instr_encoder_loader_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_JR   = 4'd5,
    K_ADDI = 4'd6,
    K_BEQ  = 4'd7,
    K_SLTI = 4'd8,
    K_LW   = 4'd9,
    K_SW   = 4'd10,
    K_J    = 4'd11,
    K_JAL  = 4'd12
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational field-to-word encoder; kinds outside the table flag illegal and
// produce a zero word.
module instr_field_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      K_ADD:   word = rtype(rs, rt, rd, FN_ADD);
      K_SUB:   word = rtype(rs, rt, rd, FN_SUB);
      K_AND:   word = rtype(rs, rt, rd, FN_AND);
      K_OR:    word = rtype(rs, rt, rd, FN_OR);
      K_SLT:   word = rtype(rs, rt, rd, FN_SLT);
      // JR only uses rs; rt/rd are forced so stray fields cannot leak into the word
      K_JR:    word = rtype(rs, 5'd0, 5'd0, FN_JR);
      K_ADDI:  word = {OP_ADDI, rs, rt, imm};
      K_BEQ:   word = {OP_BEQ,  rs, rt, imm};
      K_SLTI:  word = {OP_SLTI, rs, rt, imm};
      K_LW:    word = {OP_LW,   rs, rt, imm};
      K_SW:    word = {OP_SW,   rs, rt, imm};
      K_J:     word = {OP_J,   target};
      K_JAL:   word = {OP_JAL, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Test-program loader: accepts field-level requests, encodes them and writes one
// word per cycle into consecutive imem addresses, one cycle after acceptance.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  input  logic              last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // Handshake: a request is taken on any rising edge where req_valid_i && req_ready_o;
  // req_ready_o depends only on state, so it never reacts combinationally to valid.

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_e              state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     count;
  logic                pend_valid;
  logic [31:0]         pend_word;
  logic                err;
  logic [31:0]         enc_word;
  logic                enc_illegal;
  logic                accept;
  logic                full;
  logic                write;

  instr_field_encoder u_enc (
    .kind    (req_kind_i),
    .rs      (rs_i),
    .rt      (rt_i),
    .rd      (rd_i),
    .imm     (imm_i),
    .target  (target_i),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign accept = req_valid_i && (state == S_LOAD);
  assign full   = (count == CAP);
  assign write  = pend_valid && !full;

  // Gated by reset so a pending word is dropped in the very cycle reset is held
  assign imem_we_o    = write && rst_i;
  assign imem_addr_o  = addr;
  assign imem_wdata_o = pend_word;
  assign count_o      = count;
  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE);
  assign req_ready_o  = (state == S_LOAD);
  assign err_o        = err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      addr       <= '0;
      count      <= '0;
      pend_valid <= 1'b0;
      pend_word  <= '0;
      err        <= 1'b0;
    end else begin
      if (write) begin
        addr  <= addr + ADDR_W'(1);
        count <= count + (ADDR_W+1)'(1);
      end
      if (pend_valid && full) err <= 1'b1;

      pend_valid <= 1'b0;
      if (accept) begin
        if (enc_illegal) begin
          err <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_word  <= enc_word;
        end
      end

      case (state)
        S_IDLE: if (start_i) begin
          state <= S_LOAD;
          addr  <= ADDR_W'(START_ADDR);
          count <= '0;
          err   <= 1'b0;
        end
        S_LOAD:  if (accept && last_i) state <= S_DRAIN;
        // The last pending word (if any) is written during the single DRAIN cycle
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (256-word and 4-word imem) share
// one request stream; a reference model fills per-instance expected queues.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        valid;
  logic        last;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] tgt;

  logic        rdy8, we8, busy8, done8, err8;
  logic [7:0]  addr8;
  logic [31:0] wd8;
  logic [8:0]  cnt8;
  logic        rdy2, we2, busy2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [2:0]  cnt2;

  instr_encoder_loader #(.ADDR_W(8), .START_ADDR(0)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .req_valid_i(valid), .req_ready_o(rdy8),
    .req_kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .target_i(tgt),
    .last_i(last), .imem_we_o(we8), .imem_addr_o(addr8), .imem_wdata_o(wd8),
    .count_o(cnt8), .busy_o(busy8), .done_o(done8), .err_o(err8)
  );

  instr_encoder_loader #(.ADDR_W(2), .START_ADDR(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .req_valid_i(valid), .req_ready_o(rdy2),
    .req_kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .target_i(tgt),
    .last_i(last), .imem_we_o(we2), .imem_addr_o(addr2), .imem_wdata_o(wd2),
    .count_o(cnt2), .busy_o(busy2), .done_o(done2), .err_o(err2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state, index 0 = 256-word instance, 1 = 4-word instance
  int  m_cnt[2];
  int  m_addr[2];
  bit  m_err[2];
  int  cap[2] = '{256, 4};
  logic [39:0] exp_q0[$];
  logic [39:0] exp_q1[$];
  logic [39:0] obs_q[$];
  int          obs_t[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word layout from the ISA: R {0,rs,rt,rd,0,funct}, I {op,rs,rt,imm}, J {op,target}
  function automatic logic [31:0] ref_word(input int k, input int rs_v, input int rt_v,
                                           input int rd_v, input int imm_v, input int tgt_v,
                                           output bit ok);
    int fn[6]   = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h08};
    int op_i[5] = '{32'h08, 32'h04, 32'h0A, 32'h23, 32'h2B};
    int op_j[2] = '{32'h02, 32'h03};
    ok = 1'b1;
    if (k <= 5) begin
      if (k == 5) begin
        rt_v = 0;
        rd_v = 0;
      end
      return (32'(rs_v) << 21) | (32'(rt_v) << 16) | (32'(rd_v) << 11) | 32'(fn[k]);
    end
    if (k <= 10)
      return (32'(op_i[k-6]) << 26) | (32'(rs_v) << 21) | (32'(rt_v) << 16) | 32'(imm_v);
    if (k <= 12)
      return (32'(op_j[k-11]) << 26) | 32'(tgt_v);
    ok = 1'b0;
    return 32'd0;
  endfunction

  task automatic model_accept(input int k, input int rs_v, input int rt_v, input int rd_v,
                              input int imm_v, input int tgt_v);
    logic [31:0] w;
    bit ok;
    w = ref_word(k, rs_v, rt_v, rd_v, imm_v, tgt_v, ok);
    for (int i = 0; i < 2; i++) begin
      if (!ok) begin
        m_err[i] = 1'b1;
      end else if (m_cnt[i] < cap[i]) begin
        if (i == 0) exp_q0.push_back({8'(m_addr[i]), w});
        else        exp_q1.push_back({8'(m_addr[i]), w});
        m_cnt[i]++;
        m_addr[i] = (m_addr[i] + 1) % cap[i];
      end else begin
        m_err[i] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (we8) begin
      obs_q.push_back({addr8, wd8});
      obs_t.push_back(cyc);
      if (exp_q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL write8_unexpected: got addr %0h data %0h, expected no write", addr8, wd8);
      end else begin
        e = exp_q0.pop_front();
        chk("write8", {addr8, wd8}, e);
      end
    end
    if (we2) begin
      if (exp_q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL write2_unexpected: got addr %0h data %0h, expected no write", addr2, wd2);
      end else begin
        e = exp_q1.pop_front();
        chk("write2", {6'b0, addr2, wd2}, e);
      end
    end
  end

  // All driver tasks start and end on a falling edge
  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_addr[i] = 0;
      m_err[i]  = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
    obs_q.delete();
    obs_t.delete();
    chk("start_busy", busy8, 1);
    chk("start_err", err8, 0);
    chk("start_cnt", cnt8, 0);
  endtask

  task automatic send(input int k, input int rs_v, input int rt_v, input int rd_v,
                      input int imm_v, input int tgt_v, input bit lst);
    int guard = 0;
    valid = 1'b1;
    kind  = 4'(k);
    rs    = 5'(rs_v);
    rt    = 5'(rt_v);
    rd    = 5'(rd_v);
    imm   = 16'(imm_v);
    tgt   = 26'(tgt_v);
    last  = lst;
    while (!rdy8 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy8) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got ready 0 for 20 cycles, expected 1");
      valid = 1'b0;
      last  = 1'b0;
      return;
    end
    model_accept(k, rs_v, rt_v, rd_v, imm_v, tgt_v);
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic end_session();
    @(negedge clk);
    chk("done8", done8, 1);
    chk("done2", done2, 1);
    chk("count8", cnt8, 64'(m_cnt[0]));
    chk("count2", cnt2, 64'(m_cnt[1]));
    chk("err8", err8, 64'(m_err[0]));
    chk("err2", err2, 64'(m_err[1]));
    chk("pending8", exp_q0.size(), 0);
    chk("pending2", exp_q1.size(), 0);
    @(negedge clk);
    chk("idle_busy8", busy8, 0);
    chk("idle_done8", done8, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, rdy8, 0);
    chk({tag, "_we"}, we8, 0);
    chk({tag, "_addr"}, addr8, 0);
    chk({tag, "_wdata"}, wd8, 0);
    chk({tag, "_count"}, cnt8, 0);
    chk({tag, "_busy"}, busy8, 0);
    chk({tag, "_done"}, done8, 0);
    chk({tag, "_err"}, err8, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
    kind = '0; rs = '0; rt = '0; rd = '0; imm = '0; tgt = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single ADD
    start_session();
    send(0, 1, 2, 3, 0, 0, 1);
    end_session();
    chk("add_word", obs_q[0], {8'h00, 32'h00221820});

    // Back-to-back LW, BEQ, JAL
    start_session();
    send(9, 29, 8, 0, 4, 0, 0);
    send(7, 1, 2, 0, 16'hFFFF, 0, 0);
    send(12, 0, 0, 0, 0, 26'h10, 1);
    end_session();
    chk("b2b_lw", obs_q[0], {8'h00, 32'h8FA80004});
    chk("b2b_beq", obs_q[1], {8'h01, 32'h1022FFFF});
    chk("b2b_jal", obs_q[2], {8'h02, 32'h0C000010});
    chk("b2b_span", obs_t[2] - obs_t[0], 2);
    chk("b2b_count", cnt8, 3);

    // Illegal kind mid-stream; err stays set until the next start
    start_session();
    send(0, 1, 2, 3, 0, 0, 0);
    send(14, 1, 1, 1, 1, 1, 0);
    send(1, 4, 5, 6, 0, 0, 1);
    end_session();
    chk("illegal_writes", obs_q.size(), 2);
    chk("illegal_next_addr", obs_q[1][39:32], 1);
    repeat (3) @(negedge clk);
    chk("illegal_err_sticky", err8, 1);

    // Five ADDIs: the 4-word instance overflows on the fifth
    start_session();
    for (int i = 0; i < 5; i++) send(6, i, i + 1, 0, i * 3, 0, i == 4);
    end_session();
    chk("ovf_count2", cnt2, 4);
    chk("ovf_err2", err2, 1);
    chk("ovf_count8", cnt8, 5);

    // JR ignores rt/rd
    start_session();
    send(5, 31, 5, 7, 0, 0, 1);
    end_session();
    chk("jr_word", obs_q[0], {8'h00, 32'h03E00008});

    // start_i during LOAD is ignored; reset with a word pending drops it
    start_session();
    send(15, 0, 0, 0, 0, 0, 0);
    send(0, 1, 2, 3, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_start_count", cnt8, 1);
    chk("load_start_err", err8, 1);
    chk("load_start_busy", busy8, 1);
    valid = 1'b1;
    kind  = 4'd2;
    rs = 5'd7; rt = 5'd8; rd = 5'd9;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("rst_no_write8", we8, 0);
    chk("rst_no_write2", we2, 0);
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b1;
    @(negedge clk);

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      int n;
      start_session();
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, (1 << 26) - 1),
             j == n - 1);
      end
      end_session();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
